// File: rtl/spi_regbank_slave_if.sv
// SPI pin bundle between the MCU-facing top level and spi_regbank_slave.
// master: drives SCLK/CS/MOSI and samples MISO; slave: the register bank side.
interface spi_regbank_slave_if;
    logic spi_clk;
    logic spi_cs;
    logic spi_sdi;
    logic spi_sdo;

    modport master (output spi_clk, output spi_cs, output spi_sdi, input spi_sdo);
    modport slave  (input spi_clk, input spi_cs, input spi_sdi, output spi_sdo);
endinterface

// File: rtl/spi_regbank_slave.sv
// SPI mode-0 slave register bank: RW registers with per-register write
// strobes, read-only inputs, burst transfers with optional address increment.
// Optional feature macro: SPI_TIMEOUT_EN (idle-SCLK timeout into HOLD).
//
// state  | meaning
// IDLE   | waiting for CS low (after reset, only once CS has been seen high)
// CMD    | shifting in R/W bit + start address
// DATA   | shifting data words in/out, commit on each completed word
// HOLD   | parked after an idle-SCLK timeout until CS rises
module spi_regbank_slave #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_RW      = 16,
    parameter int NUM_RO      = 8,
    parameter int AUTO_INC    = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     theClock,
    input  logic                     theReset,
    spi_regbank_slave_if.slave       spi,
    output logic [NUM_RW*DATA_W-1:0] rw_regs,
    input  logic [NUM_RO*DATA_W-1:0] ro_regs,
    output logic [NUM_RW-1:0]        wr_strobe,
    output logic                     busy,
    output logic                     timeout_flag
);
    localparam int SH_W  = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;
    localparam int CNT_W = $clog2(SH_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_HOLD} state_t;

    state_t                    state_q, state_d;
    logic                      sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic                      cs_s1_q, cs_s2_q;
    logic                      sdi_s1_q, sdi_s2_q;
    logic                      arm_q, arm_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SH_W-1:0]           rx_q, rx_d;
    logic [DATA_W-1:0]         tx_q, tx_d;
    logic [ADDR_W-1:0]         addr_q, addr_d, addr_nxt;
    logic                      wr_q, wr_d;
    logic                      skip_q, skip_d;
    logic [NUM_RW*DATA_W-1:0]  rw_regs_q, rw_regs_d;
    logic [NUM_RW-1:0]         wr_strobe_q, wr_strobe_d;
    logic                      sclk_rise, sclk_fall;
    logic [ADDR_W:0]           cmd_word;
    logic [DATA_W-1:0]         data_word;

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign cmd_word  = {rx_q[ADDR_W-1:0], sdi_s2_q};
    assign data_word = {rx_q[DATA_W-2:0], sdi_s2_q};

    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a,
                                                   input logic [NUM_RW*DATA_W-1:0] rw,
                                                   input logic [NUM_RO*DATA_W-1:0] ro);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_RW; i++)
            if (a == ADDR_W'(i)) v = rw[i*DATA_W +: DATA_W];
        for (int j = 0; j < NUM_RO; j++)
            if (a == ADDR_W'(NUM_RW + j)) v = ro[j*DATA_W +: DATA_W];
        return v;
    endfunction

`ifdef SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_q, idle_d;
    logic            to_flag_q, to_flag_d;
    assign timeout_flag = to_flag_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign timeout_flag   = 1'b0;
`endif

    // Next-state, shift, commit and reload logic for the frame FSM.
    always_comb begin
        state_d     = state_q;
        arm_d       = arm_q | cs_s2_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        skip_d      = skip_q;
        rw_regs_d   = rw_regs_q;
        wr_strobe_d = '0;
        addr_nxt    = addr_q + ADDR_W'(AUTO_INC);
`ifdef SPI_TIMEOUT_EN
        idle_d      = idle_q;
        to_flag_d   = to_flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                rx_d      = '0;
                skip_d    = 1'b0;
                if (!cs_s2_q && arm_q) state_d = S_CMD;
            end
            S_CMD: begin
                if (sclk_rise) begin
                    if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                        wr_d      = cmd_word[ADDR_W];
                        addr_d    = cmd_word[ADDR_W-1:0];
                        tx_d      = read_val(cmd_word[ADDR_W-1:0], rw_regs_q, ro_regs);
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        skip_d    = 1'b1;
                        state_d   = S_DATA;
                    end else begin
                        rx_d      = {rx_q[SH_W-2:0], sdi_s2_q};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (sclk_rise) begin
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        if (wr_q) begin
                            for (int i = 0; i < NUM_RW; i++) begin
                                if (addr_q == ADDR_W'(i)) begin
                                    rw_regs_d[i*DATA_W +: DATA_W] = data_word;
                                    wr_strobe_d[i]                = 1'b1;
                                end
                            end
                        end
                        addr_d    = addr_nxt;
                        tx_d      = read_val(addr_nxt, rw_regs_q, ro_regs);
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        skip_d    = 1'b1;
                    end else begin
                        rx_d      = {rx_q[SH_W-2:0], sdi_s2_q};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // The fall right after a load would drop the fresh MSB.
                    if (skip_q) skip_d = 1'b0;
                    else        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
            end
            S_HOLD: ;
            default: state_d = S_IDLE;
        endcase
`ifdef SPI_TIMEOUT_EN
        if (state_q == S_CMD || state_q == S_DATA) begin
            if (sclk_rise || sclk_fall) begin
                idle_d = TO_W'(TIMEOUT_CYC - 1);
            end else if (idle_q == '0) begin
                state_d   = S_HOLD;
                to_flag_d = 1'b1;
            end else begin
                idle_d = idle_q - TO_W'(1);
            end
        end else begin
            idle_d = TO_W'(TIMEOUT_CYC - 1);
        end
`endif
        // CS release always wins; a word finishing this cycle still commits.
        if (cs_s2_q && state_q != S_IDLE) state_d = S_IDLE;
    end

    // Pin synchronisers plus all state registers, synchronous reset.
    always_ff @(posedge theClock) begin
        if (theReset) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_s3_q   <= 1'b0;
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            sdi_s1_q    <= 1'b0;
            sdi_s2_q    <= 1'b0;
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            skip_q      <= 1'b0;
            rw_regs_q   <= {NUM_RW{RESET_VAL}};
            wr_strobe_q <= '0;
`ifdef SPI_TIMEOUT_EN
            idle_q      <= TO_W'(TIMEOUT_CYC - 1);
            to_flag_q   <= 1'b0;
`endif
        end else begin
            sclk_s1_q   <= spi.spi_clk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_s3_q   <= sclk_s2_q;
            cs_s1_q     <= spi.spi_cs;
            cs_s2_q     <= cs_s1_q;
            sdi_s1_q    <= spi.spi_sdi;
            sdi_s2_q    <= sdi_s1_q;
            state_q     <= state_d;
            arm_q       <= arm_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            skip_q      <= skip_d;
            rw_regs_q   <= rw_regs_d;
            wr_strobe_q <= wr_strobe_d;
`ifdef SPI_TIMEOUT_EN
            idle_q      <= idle_d;
            to_flag_q   <= to_flag_d;
`endif
        end
    end

    assign spi.spi_sdo = (state_q == S_DATA) ? tx_q[DATA_W-1] : 1'b0;
    assign rw_regs     = rw_regs_q;
    assign wr_strobe   = wr_strobe_q;
    assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_spi_regbank_slave.sv
// Scoreboard bench for spi_regbank_slave: directed SPI frames push expected
// strobes / read words into queues, independent monitors pop and compare.
module tb_spi_regbank_slave;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 7;
    localparam int NUM_RW = 16;
    localparam int NUM_RO = 8;
    localparam int HALF   = 8;

    logic                     theClock;
    logic                     theReset;
    logic [NUM_RW*DATA_W-1:0] rw_regs;
    logic [NUM_RO*DATA_W-1:0] ro_regs;
    logic [NUM_RW-1:0]        wr_strobe;
    logic                     busy;
    logic                     timeout_flag;

    spi_regbank_slave_if spi_if ();

    spi_regbank_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO),
        .AUTO_INC(1), .RESET_VAL(8'h00), .TIMEOUT_CYC(64)
    ) dut (
        .theClock(theClock), .theReset(theReset), .spi(spi_if.slave),
        .rw_regs(rw_regs), .ro_regs(ro_regs), .wr_strobe(wr_strobe),
        .busy(busy), .timeout_flag(timeout_flag)
    );

    int checks   = 0;
    int failures = 0;

    int         exp_idx_q[$];
    logic [7:0] exp_dat_q[$];
    logic [7:0] exp_rd_q[$];
    logic [NUM_RW*DATA_W-1:0] exp_regs;
    logic [7:0] rd_word;
    event       rd_ev;
    logic       exp_to;

    initial begin
        theClock = 1'b0;
        forever #5 theClock = ~theClock;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Strobe monitor: every nonzero strobe cycle must match the next expected write.
    always @(negedge theClock) begin
        if (!theReset && wr_strobe != '0) begin
            if (exp_idx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=%0h required=0", wr_strobe);
            end else begin
                int idx;
                logic [7:0] dat;
                logic [NUM_RW-1:0] one;
                idx = exp_idx_q.pop_front();
                dat = exp_dat_q.pop_front();
                one = 16'b1 << idx;
                check("strobe_onehot", 128'(wr_strobe), 128'(one));
                check("strobe_reg_value", 128'(rw_regs[idx*8 +: 8]), 128'(dat));
            end
        end
    end

    // Read monitor: each completed MISO word is compared with the next expected one.
    always @(rd_ev) begin
        if (exp_rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read actual=%0h required=none", rd_word);
        end else begin
            check("read_word", 128'(rd_word), 128'(exp_rd_q.pop_front()));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge theClock);
    endtask

    task automatic shift_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            spi_if.spi_sdi = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], spi_if.spi_sdo};
            spi_if.spi_clk = 1'b1;
            wait_clk(HALF);
            spi_if.spi_clk = 1'b0;
        end
    endtask

    // Full frame: command, nwords data words (packed MSB-first), optional partial word.
    task automatic spi_frame(input logic [7:0] cmd, input int nwords, input logic [31:0] words,
                             input bit rd, input int partial_bits);
        logic [7:0] rxw;
        spi_if.spi_cs = 1'b0;
        wait_clk(HALF);
        shift_bits(cmd, 8, rxw);
        for (int k = 0; k < nwords; k++) begin
            shift_bits(words[31-8*k -: 8], 8, rxw);
            if (rd) begin
                rd_word = rxw;
                -> rd_ev;
            end
        end
        if (partial_bits > 0) shift_bits(words[31-8*nwords -: 8], partial_bits, rxw);
        wait_clk(HALF);
        spi_if.spi_cs  = 1'b1;
        spi_if.spi_sdi = 1'b0;
        wait_clk(2*HALF);
    endtask

    task automatic expect_wr(input int idx, input logic [7:0] dat);
        exp_idx_q.push_back(idx);
        exp_dat_q.push_back(dat);
        exp_regs[idx*8 +: 8] = dat;
    endtask

    logic [7:0] dummy;

    initial begin
`ifdef SPI_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        theReset       = 1'b1;
        spi_if.spi_clk = 1'b0;
        spi_if.spi_cs  = 1'b1;
        spi_if.spi_sdi = 1'b0;
        ro_regs        = '0;
        ro_regs[7:0]   = 8'hA5;
        ro_regs[15:8]  = 8'h3B;
        exp_regs       = '0;
        wait_clk(5);
        #1;
        check("reset_rw_regs", 128'(rw_regs), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_strobe", 128'(wr_strobe), 128'(0));
        check("reset_sdo", 128'(spi_if.spi_sdo), 128'(0));
        check("reset_timeout", 128'(timeout_flag), 128'(0));
        theReset = 1'b0;
        wait_clk(2*HALF);

        // 1: single write 0x83 / 0x5A
        expect_wr(3, 8'h5A);
        spi_if.spi_cs = 1'b0;
        wait_clk(HALF);
        #1 check("busy_in_frame", 128'(busy), 128'(1));
        spi_if.spi_cs = 1'b1;
        wait_clk(2*HALF);
        spi_frame(8'h83, 1, 32'h5A000000, 1'b0, 0);
        check("regs_after_single", 128'(rw_regs), 128'(exp_regs));
        check("busy_after_frame", 128'(busy), 128'(0));

        // 2: burst write from 0
        expect_wr(0, 8'h11);
        expect_wr(1, 8'h22);
        expect_wr(2, 8'h33);
        spi_frame(8'h80, 3, 32'h11223300, 1'b0, 0);
        check("regs_after_burst", 128'(rw_regs), 128'(exp_regs));

        // 3: burst read across RW/RO boundary, unmapped read and address wrap
        expect_wr(15, 8'hC7);
        spi_frame(8'h8F, 1, 32'hC7000000, 1'b0, 0);
        exp_rd_q.push_back(8'hC7);
        exp_rd_q.push_back(8'hA5);
        exp_rd_q.push_back(8'h3B);
        spi_frame(8'h0F, 3, 32'h00000000, 1'b1, 0);
        exp_rd_q.push_back(8'h00);
        exp_rd_q.push_back(8'h11);
        spi_frame(8'h7F, 2, 32'h00000000, 1'b1, 0);

        // 4: ignored writes (RO, unmapped) and a partial word
        spi_frame(8'h90, 1, 32'hFF000000, 1'b0, 0);
        spi_frame(8'hFF, 1, 32'h12000000, 1'b0, 0);
        spi_frame(8'h82, 0, 32'hAB000000, 1'b0, 5);
        check("regs_after_ignored", 128'(rw_regs), 128'(exp_regs));
        exp_rd_q.push_back(8'hA5);
        spi_frame(8'h10, 1, 32'h00000000, 1'b1, 0);

        // 5: reset mid-burst, frame ignored until CS has gone high
        expect_wr(0, 8'h44);
        spi_if.spi_cs = 1'b0;
        wait_clk(HALF);
        shift_bits(8'h80, 8, dummy);
        shift_bits(8'h44, 8, dummy);
        shift_bits(8'h55, 3, dummy);
        wait_clk(4);
        theReset = 1'b1;
        wait_clk(3);
        theReset = 1'b0;
        exp_regs = '0;
        wait_clk(4);
        #1;
        check("midreset_regs", 128'(rw_regs), 128'(0));
        check("midreset_busy", 128'(busy), 128'(0));
        shift_bits(8'h55 << 3, 5, dummy);
        shift_bits(8'h77, 8, dummy);
        #1 check("unarmed_busy", 128'(busy), 128'(0));
        spi_if.spi_cs = 1'b1;
        wait_clk(2*HALF);
        check("unarmed_regs", 128'(rw_regs), 128'(0));
        expect_wr(1, 8'h3C);
        spi_frame(8'h81, 1, 32'h3C000000, 1'b0, 0);
        check("regs_after_reset_frame", 128'(rw_regs), 128'(exp_regs));

        // 6: SCLK stalls after 4 bits with CS low
        spi_if.spi_cs = 1'b0;
        wait_clk(HALF);
        shift_bits(8'h84, 4, dummy);
        wait_clk(40);
        #1 check("timeout_not_early", 128'(timeout_flag), 128'(0));
        wait_clk(160);
        #1;
        check("timeout_flag", 128'(timeout_flag), 128'(exp_to));
        check("stall_busy", 128'(busy), 128'(1));
        spi_if.spi_cs = 1'b1;
        wait_clk(2*HALF);
        #1;
        check("stall_busy_released", 128'(busy), 128'(0));
        check("timeout_sticky", 128'(timeout_flag), 128'(exp_to));
        check("regs_final", 128'(rw_regs), 128'(exp_regs));
        check("pending_strobes", 128'(exp_idx_q.size()), 128'(0));
        check("pending_reads", 128'(exp_rd_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_regbank_slave.md
Name: spi_regbank_slave

Overview:
- Parametrised SPI-slave register bank. It is the next generation of the single-byte SPI register interface between the external MCU and the FPGA game and display logic.
- Supports configurable data width, configurable read/write and read-only register counts, burst transfers with address auto-increment, and per-register write strobes. Per-register strobes generalise the single "Trigger" pulse.
- Sits between the SPI pins at the top level and the game, colour and accelerometer logic, all in the system clock domain.

Parameters:
- DATA_W, 8, bits per data word; legal 8..32.
- ADDR_W, 7, address bits in the command byte; the command byte is 1+ADDR_W bits.
- NUM_RW, 16, writable registers at addresses 0..NUM_RW-1.
- NUM_RO, 8, read-only registers at addresses NUM_RW..NUM_RW+NUM_RO-1; NUM_RW+NUM_RO <= 2^ADDR_W.
- AUTO_INC, 1, 1 = address increments after each data word; 0 = address held (streaming to a single register).
- RESET_VAL, 0, reset value of every RW register (DATA_W bits).
- TIMEOUT_CYC, 4096, idle-SCLK limit in theClock cycles; used only with SPI_TIMEOUT_EN.

Ports:
- theClock  in  1  system clock.
- theReset  in  1  synchronous, active-high reset.
- spi_clk  in  1  SCLK, asynchronous.
- spi_cs  in  1  chip select, active low, asynchronous.
- spi_sdi  in  1  MOSI, asynchronous.
- spi_sdo  out  1  MISO.
- rw_regs  out  NUM_RW*DATA_W  flattened RW registers; register i occupies bits [i*DATA_W +: DATA_W].
- ro_regs  in  NUM_RO*DATA_W  flattened read-only inputs, same packing.
- wr_strobe  out  NUM_RW  one-cycle pulse per RW register on commit.
- busy  out  1  high while a frame is in progress.
- timeout_flag  out  1  sticky timeout indicator; tied 0 without the macro.

Behaviour:
- Clock and reset: one clock (theClock), synchronous active-high reset (theReset).
- Synchronisation and edge detection:
  - spi_clk, spi_cs and spi_sdi each pass through a 2-FF synchroniser.
  - Rise and fall detects are derived from the synchronised SCLK.
  - Requirement: SCLK <= theClock/8.
- SPI mode: mode 0 only. Sample on SCLK rise, shift the output on SCLK fall, MSB first.
- Frame format:
  - Command word first: bit ADDR_W is R/W (1 = write), bits [ADDR_W-1:0] are the start address.
  - Then 0..N data words of DATA_W bits each.
- FSM states: IDLE, CMD, DATA, HOLD.
  - IDLE -> CMD when synchronised CS is low. The bit counter clears on entry.
  - CMD: shift spi_sdi in on each rise. After the (ADDR_W+1)-th rise:
    - latch address and R/W;
    - load tx_shift with the read value of that address;
    - go to DATA with the counter cleared.
  - DATA: shift rx on each rise. After the DATA_W-th rise:
    - if write and address < NUM_RW: the register takes rx on the next cycle and the matching wr_strobe bit pulses for exactly one cycle;
    - address += AUTO_INC, modulo 2^ADDR_W;
    - tx_shift is reloaded from the new address;
    - stay in DATA.
  - HOLD: entered only on timeout. Exits to IDLE when CS goes high.
  - From any state, CS high -> IDLE on the next cycle.
- Read data:
  - Addresses < NUM_RW return the rw_regs value.
  - Addresses in the RO range return the ro_regs value.
  - Unmapped addresses return 0.
  - The read value is captured at load time.
- Output shifting:
  - tx_shift shifts left on every SCLK fall in DATA, except the fall that immediately follows a word-final rise; that fall is absorbed by the reload.
  - spi_sdo = tx_shift MSB in DATA; 0 in IDLE, CMD and HOLD.
- Ignored accesses:
  - Writes to RO or unmapped addresses are dropped; no strobe.
  - Read frames never pulse wr_strobe.
- Partial words:
  - A partial word at CS rise is discarded; no write, no strobe.
  - If a word completes in the same cycle that CS rises, the write commits.
- busy = (state != IDLE).
- Reset, including mid-frame:
  - state IDLE; all rw_regs = RESET_VAL.
  - wr_strobe = 0, spi_sdo = 0, counters and shift registers = 0, timeout_flag = 0.
  - An in-flight frame is abandoned. The block resumes at the next CS fall seen after reset has deasserted and CS has gone high.

Optional Feature:
- Macro: SPI_TIMEOUT_EN.
- With the macro:
  - an idle counter runs while state is CMD or DATA;
  - it clears on any synchronised SCLK edge;
  - on reaching TIMEOUT_CYC: go to HOLD, set timeout_flag (sticky until theReset), and discard the partial word.
- Without the macro: no counter, HOLD is unreachable, and timeout_flag is constant 0.

Test Plan:
1. Reset, then single write: DATA_W=8, cmd 0x83, data 0x5A → rw_regs reg3 = 0x5A; wr_strobe[3] pulses exactly once; no other register changes.
2. Burst write with AUTO_INC=1: cmd 0x80, data 0x11, 0x22, 0x33 → regs 0..2 = 0x11, 0x22, 0x33; three strobes in order.
3. Burst read spanning regions with NUM_RW=16: ro_regs reg0 = 0xA5, cmd 0x0F, read 3 words → MISO returns reg15, then 0xA5, then ro reg1. Unmapped address 0x7F reads 0x00.
4. Write to RO address 0x10 with data 0xFF → no strobe, no state change. CS raised after 5 data bits of cmd 0x82 → reg2 unchanged, no strobe.
5. theReset asserted mid-burst after the first word committed → all registers return to RESET_VAL. The next full frame (cmd 0x81, data 0x3C) writes reg1 = 0x3C.
6. With SPI_TIMEOUT_EN, TIMEOUT_CYC=64: CS held low, SCLK stopped after 4 bits → timeout_flag = 1 on cycle 64, busy stays high and state is HOLD until CS rises, no write. Without the macro the same stimulus gives timeout_flag = 0.
